ctrl_pipe_chain: RTL and testbench
==================================

// Module: ctrl_pipe_chain
// PURPOSE
//   Parametrised control-word pipeline for the pipelined MIPS core.
//   - Carries the decoded control word and a valid bit from decode through STAGES registered stages (E, M, W, ...).
//   - Supports a per-stage stall (hold) and a per-stage flush (bubble).
//   - Stalls propagate toward decode; bubbles are inserted automatically behind a held stage.
//   - Replaces the fixed-width, fixed-depth E/M/W control registers and generalises them to any stage count and word width.
// PARAMETERS
//   W       10  control-word width per stage (bits)
//   STAGES  3   number of pipeline stages after decode; must be >= 1
//   CNT_W   16  performance-counter width; used only with CTRL_PIPE_PERF_EN
// PORTS
//   clk          in   1          core clock, rising edge
//   reset        in   1          synchronous, active-high
//   ctrl_in      in   W          decoded control word from decode stage
//   valid_in     in   1          ctrl_in holds a real instruction
//   stall        in   STAGES     stall[k]=1: stage k holds its contents
//   flush        in   STAGES     flush[k]=1: stage k loads a bubble
//   ctrl_out     out  STAGES*W   stage k word at [k*W +: W]; stage 0 = E
//   valid_out    out  STAGES     per-stage valid bit
//   hold_up      out  1          decode must hold: hold[0], combinational
//   stall_cnt    out  CNT_W      cycles in which hold_up=1 (perf option)
//   bubble_cnt   out  CNT_W      bubbles inserted by hold rule (perf option)
// BEHAVIOUR
//   - Effective hold: hold[k] = OR(stall[j]) for j = k .. STAGES-1.
//     - A stalled later stage freezes every earlier stage.
//     - hold_up = hold[0], combinational from stall[].
//   - Stage input: stage 0 takes {valid_in, ctrl_in}; stage k>0 takes the contents of stage k-1.
//   - Per-stage update on each rising clk edge, in priority order:
//     1. reset: ctrl=0, valid=0.
//     2. flush[k]: ctrl=0, valid=0. Flush wins over stall; a flushed stage that is held still becomes a bubble.
//     3. hold[k]: keep the current contents.
//     4. k>0, hold[k-1]=1 and hold[k]=0: auto-bubble (ctrl=0, valid=0). This prevents duplicating the held instruction.
//     5. Otherwise load the stage input.
//   - Bubble value is all-zero. All-zero control never writes memory or the register file.
//   - Latency: a word at ctrl_in appears at stage k after k+1 un-held edges.
//   - Outputs are registered, except hold_up.
//   - When valid_in=0, ctrl_in is still loaded as given. The valid bit does not gate the control word.
//   - If every stage is held, the whole pipe freezes and no bubble is created.
//   - stall and flush may both be set on the same stage in the same cycle; rule 2 applies.
//   - Reset asserted mid-operation clears every stage on that edge, independent of stall and flush.
// CONFIGURATION
//   - CTRL_PIPE_PERF_EN defined:
//     - stall_cnt increments on each edge with hold_up=1.
//     - bubble_cnt increments on each edge where rule 4 fires, by the number of stages it fires in (0..STAGES-1).
//     - Both counters saturate at all-ones and clear on reset.
//   - CTRL_PIPE_PERF_EN undefined: counters are not built; stall_cnt and bubble_cnt are tied to 0.
// TESTING (STAGES=3, W=10)
//   - Reset: hold reset 2 cycles with random inputs.
//     -> ctrl_out=0, valid_out=3'b000; hold_up follows stall[].
//   - Streaming: push A=0x2A1, B=0x155, C=0x0F0 back-to-back with valid_in=1, no stall or flush.
//     -> A appears at stages 0, 1, 2 on edges 1, 2, 3; B and C follow one cycle apart.
//   - Load-use stall: stall[0]=1 for 1 cycle while stage 0 holds A.
//     -> hold_up=1; stage 0 keeps A; stage 1 gets a bubble (valid=0, ctrl=0); next cycle A moves to stage 1.
//   - Back-pressure: stall[2]=1 for 2 cycles.
//     -> all stages frozen, hold_up=1, no bubbles; pipe resumes unchanged.
//   - Flush beats stall: flush[0]=1 and stall[0]=1 in the same cycle.
//     -> stage 0 valid=0, ctrl=0; hold_up=1.
//   - Perf (macro defined): 5 stall[0] cycles, then reset.
//     -> stall_cnt=5 and bubble_cnt=5; both read 0 after reset. With the macro undefined, both always read 0.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_chain
// Description : Control-word pipeline with per-stage hold/flush and automatic
//               bubble insertion. Optional perf counters via CTRL_PIPE_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipe_chain #(
    parameter int W      = 10,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          ctrl_in,
    input  logic                  valid_in,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   ctrl_out,
    output logic [STAGES-1:0]     valid_out,
    output logic                  hold_up,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [STAGES-1:0][W-1:0] r_ctrl;
    logic [STAGES-1:0]        r_valid;
    logic [STAGES-1:0][W-1:0] w_in_ctrl;
    logic [STAGES-1:0]        w_in_valid;
    logic [STAGES-1:0]        w_hold;
    logic [STAGES-1:0]        w_abub;

    // A stall anywhere downstream freezes every stage in front of it.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_hold
            if (k == STAGES - 1) begin : g_last
                assign w_hold[k] = stall[k];
            end else begin : g_mid
                assign w_hold[k] = stall[k] | w_hold[k+1];
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_in
            if (k == 0) begin : g_first
                assign w_in_ctrl[k]  = ctrl_in;
                assign w_in_valid[k] = valid_in;
                assign w_abub[k]     = 1'b0;
            end else begin : g_rest
                assign w_in_ctrl[k]  = r_ctrl[k-1];
                assign w_in_valid[k] = r_valid[k-1];
                // Upstream is held but this stage moves: fill with a bubble
                // rather than duplicating the held instruction.
                assign w_abub[k]     = w_hold[k-1] & ~w_hold[k];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= '0;
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k] || w_abub[k]) begin
                    r_ctrl[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else if (!w_hold[k]) begin
                    r_ctrl[k]  <= w_in_ctrl[k];
                    r_valid[k] <= w_in_valid[k];
                end
            end
        end
    end

    assign ctrl_out  = r_ctrl;
    assign valid_out = r_valid;
    assign hold_up   = w_hold[0];

`ifdef CTRL_PIPE_PERF_EN
    localparam logic [CNT_W:0] c_one = 1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W:0]   w_bub_n;
    logic [CNT_W:0]   w_stall_sum;
    logic [CNT_W:0]   w_bubble_sum;

    // Flush has priority over the auto-bubble, so it is not counted there.
    always_comb begin
        w_bub_n = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (w_abub[k] && !flush[k]) begin
                w_bub_n = w_bub_n + c_one;
            end
        end
    end

    assign w_stall_sum  = {1'b0, r_stall_cnt} + c_one;
    assign w_bubble_sum = {1'b0, r_bubble_cnt} + w_bub_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_hold[0]) begin
                r_stall_cnt <= w_stall_sum[CNT_W] ? '1 : w_stall_sum[CNT_W-1:0];
            end
            r_bubble_cnt <= w_bubble_sum[CNT_W] ? '1 : w_bubble_sum[CNT_W-1:0];
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe_chain
// Description : Directed self-checking bench for ctrl_pipe_chain (3 x 10 bit).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe_chain;

    localparam int W      = 10;
    localparam int STAGES = 3;
    localparam int CNT_W  = 16;

    localparam logic [W-1:0] c_a = 10'h2A1;
    localparam logic [W-1:0] c_b = 10'h155;
    localparam logic [W-1:0] c_c = 10'h0F0;
    localparam logic [W-1:0] c_d = 10'h3FF;
    localparam logic [W-1:0] c_z = 10'h000;

`ifdef CTRL_PIPE_PERF_EN
    localparam int c_perf_exp = 5;
`else
    localparam int c_perf_exp = 0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [W-1:0]        ctrl_in;
    logic                valid_in;
    logic [STAGES-1:0]   stall;
    logic [STAGES-1:0]   flush;
    logic [STAGES*W-1:0] ctrl_out;
    logic [STAGES-1:0]   valid_out;
    logic                hold_up;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_pipe_chain #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .stall      (stall),
        .flush      (flush),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .hold_up    (hold_up),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected words are given as stage 2, stage 1, stage 0.
    task automatic check_pipe(input string tag, input logic [W-1:0] s2, input logic [W-1:0] s1,
                              input logic [W-1:0] s0, input logic [2:0] v);
        check({tag, ".ctrl"}, 32'(ctrl_out), 32'({s2, s1, s0}));
        check({tag, ".valid"}, 32'(valid_out), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] c, input logic v);
        ctrl_in  = c;
        valid_in = v;
    endtask

    initial begin
        reset = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = '0; flush = '0;

        // Reset with random inputs on the other ports
        for (int i = 0; i < 2; i++) begin
            ctrl_in  = W'($urandom);
            valid_in = 1'($urandom);
            stall    = STAGES'($urandom);
            flush    = STAGES'($urandom);
            step();
            check_pipe("reset", c_z, c_z, c_z, 3'b000);
            check("reset.hold_up", 32'(hold_up), 32'(|stall));
        end
        reset = 1'b0; stall = '0; flush = '0;

        // Streaming A, B, C
        drive(c_a, 1'b1); step(); check_pipe("stream1", c_z, c_z, c_a, 3'b001);
        drive(c_b, 1'b1); step(); check_pipe("stream2", c_z, c_a, c_b, 3'b011);
        drive(c_c, 1'b1); step(); check_pipe("stream3", c_a, c_b, c_c, 3'b111);
        check("stream.hold_up", 32'(hold_up), 32'd0);
        drive(c_z, 1'b0); step(); check_pipe("stream4", c_b, c_c, c_z, 3'b110);
        drive(c_a, 1'b1); step(); check_pipe("stream5", c_c, c_z, c_a, 3'b101);

        // Load-use stall on stage 0
        drive(c_b, 1'b1); stall = 3'b001; #1;
        check("loaduse.hold_up", 32'(hold_up), 32'd1);
        step(); check_pipe("loaduse1", c_z, c_z, c_a, 3'b001);
        stall = 3'b000; step(); check_pipe("loaduse2", c_z, c_a, c_b, 3'b011);

        // Back-pressure from the last stage
        drive(c_c, 1'b1); step(); check_pipe("bp_fill", c_a, c_b, c_c, 3'b111);
        drive(c_d, 1'b1); stall = 3'b100; #1;
        check("bp.hold_up", 32'(hold_up), 32'd1);
        step(); check_pipe("bp1", c_a, c_b, c_c, 3'b111);
        step(); check_pipe("bp2", c_a, c_b, c_c, 3'b111);
        stall = 3'b000; step(); check_pipe("bp_resume", c_b, c_c, c_d, 3'b111);

        // Middle stall: stages 0 and 1 hold, stage 2 gets a bubble
        drive(c_a, 1'b1); stall = 3'b010; step();
        check_pipe("midstall", c_z, c_c, c_d, 3'b011);
        check("midstall.hold_up", 32'(hold_up), 32'd1);
        stall = 3'b000; step(); check_pipe("midstall_go", c_c, c_d, c_a, 3'b111);

        // Flush beats stall on stage 0
        drive(c_b, 1'b1); stall = 3'b001; flush = 3'b001; step();
        check_pipe("flush_stall", c_d, c_z, c_z, 3'b100);
        check("flush_stall.hold_up", 32'(hold_up), 32'd1);

        // Flush of the last stage only
        drive(c_b, 1'b1); stall = 3'b000; flush = 3'b100; step();
        check_pipe("flush2", c_z, c_z, c_b, 3'b001);
        flush = 3'b000;

        // valid_in=0 still loads the control word
        drive(c_c, 1'b0); step(); check_pipe("novalid", c_z, c_b, c_c, 3'b010);

        // Reset mid-operation wins over stall and flush
        reset = 1'b1; stall = 3'b100; flush = 3'b010; step();
        check_pipe("midreset", c_z, c_z, c_z, 3'b000);
        check("midreset.stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0; stall = '0; flush = '0;

        // Perf: five stall[0] cycles, each inserting one bubble at stage 1
        drive(c_a, 1'b1); stall = 3'b001;
        for (int i = 0; i < 5; i++) step();
        check("perf.stall_cnt", 32'(stall_cnt), 32'(c_perf_exp));
        check("perf.bubble_cnt", 32'(bubble_cnt), 32'(c_perf_exp));
        stall = 3'b000; #1;
        check("perf.hold_up_low", 32'(hold_up), 32'd0);
        reset = 1'b1; step();
        check("perf.stall_cnt_rst", 32'(stall_cnt), 32'd0);
        check("perf.bubble_cnt_rst", 32'(bubble_cnt), 32'd0);
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
